ultrasonic_ranger: RTL and testbench

- Consumes the debounced push-button level and runs one HC-SR04-style ranging cycle per press.
- Each cycle drives the sensor trigger pulse, times the returned echo pulse and converts the width to whole centimetres.
- Publishes the distance with a one-cycle valid strobe to the display/readout stage downstream.
- Single clock domain. Only the sensor echo input is asynchronous.

---
 rtl/ultrasonic_ranger.sv | 113 +++++++++++
 tb/tb_ultrasonic_ranger.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 style trigger/echo ranging, echo width converted to cm by counting 58 us steps.
// Define ULTRASONIC_CONT_MEAS_EN for continuous ranging after the first start press.
module ultrasonic_ranger #(
    parameter int CLKSPDMHZ  = 100,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int HOLDOFF_US = 60000,
    parameter int DIST_W     = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              echo,
    output logic              trig,
    output logic              busy,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_valid,
    output logic              timeout
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;
    localparam int PW   = $clog2(CLKSPDMHZ);
    localparam int UMAX = TIMEOUT_US > HOLDOFF_US ? (TIMEOUT_US > TRIG_US ? TIMEOUT_US : TRIG_US)
                                                  : (HOLDOFF_US > TRIG_US ? HOLDOFF_US : TRIG_US);
    localparam int UW   = $clog2(UMAX + 1);

    state_t            state, state_n;
    logic [PW-1:0]     presc;
    logic [UW-1:0]     us_cnt;
    logic [5:0]        sub58;
    logic [DIST_W-1:0] cm_cnt, cm_nxt, dist_d;
    logic              echo_m, echo_s, start_q, start_rise, us_tick, cm_wrap;
    logic              trig_end, to_end, ho_end, meas_done, to_hit;
    logic              trig_d, valid_d, to_d, cont, moved;

    assign start_rise = start & ~start_q;
    assign us_tick    = presc == PW'(CLKSPDMHZ - 1);
    assign trig_end   = us_tick && us_cnt == UW'(TRIG_US - 1);
    assign to_end     = us_tick && us_cnt == UW'(TIMEOUT_US - 1);
    assign ho_end     = us_tick && us_cnt == UW'(HOLDOFF_US - 1);
    assign cm_wrap    = us_tick && sub58 == 6'd57;
    // Include this cycle's tick so the final microsecond of the echo is counted.
    assign cm_nxt     = (cm_wrap && cm_cnt != '1) ? cm_cnt + 1'b1 : cm_cnt;
    assign meas_done  = state == MEASURE && !echo_s;
    assign to_hit     = to_end && ((state == WAIT_ECHO && !echo_s) || (state == MEASURE && echo_s));
    assign busy       = state != IDLE;
    assign moved      = state_n != state;

`ifdef ULTRASONIC_CONT_MEAS_EN
    // Armed by a press from IDLE; any later press disarms, letting the current cycle finish.
    always_ff @(posedge clk) begin
        if (reset)
            cont <= 1'b0;
        else if (start_rise)
            cont <= state == IDLE;
    end
`else
    assign cont = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start_rise ? TRIG : IDLE;
            TRIG:      state_n = trig_end ? WAIT_ECHO : TRIG;
            WAIT_ECHO: state_n = echo_s ? MEASURE : (to_hit ? HOLDOFF : WAIT_ECHO);
            MEASURE:   state_n = (meas_done || to_hit) ? HOLDOFF : MEASURE;
            HOLDOFF:   state_n = ho_end ? (cont ? TRIG : IDLE) : HOLDOFF;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        trig_d  = state_n == TRIG;
        valid_d = meas_done || to_hit;
        to_d    = to_hit;
        dist_d  = to_hit ? '1 : (meas_done ? cm_nxt : dist_cm);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            echo_m     <= 1'b0;
            echo_s     <= 1'b0;
            start_q    <= 1'b0;
            presc      <= '0;
            us_cnt     <= '0;
            sub58      <= '0;
            cm_cnt     <= '0;
            trig       <= 1'b0;
            dist_cm    <= '0;
            dist_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            echo_m     <= echo;
            echo_s     <= echo_m;
            start_q    <= start;
            presc      <= (moved || us_tick) ? '0 : presc + 1'b1;
            us_cnt     <= moved ? '0 : us_cnt + UW'(us_tick);
            sub58      <= (moved || cm_wrap) ? '0 : sub58 + 6'(us_tick);
            cm_cnt     <= moved ? '0 : cm_nxt;
            trig       <= trig_d;
            dist_cm    <= dist_d;
            dist_valid <= valid_d;
            timeout    <= to_d;
        end
    end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: directed vectors and hand sequences for ultrasonic_ranger at 10 MHz.
module tb_ultrasonic_ranger;
    localparam int CLK = 10;

    typedef struct {
        int d_us;
        int w_us;
        int exp_dist;
        int exp_to;
    } vec_t;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, echo = 1'b0;
    logic       trig, busy, dist_valid, timeout;
    logic [8:0] dist_cm;
    int         total = 0, bad = 0, cyc = 0, vcount = 0, t_valid = 0, t_prev = 0, t_bfall = 0;
    int         last_dist = 0, last_to = 0;
    logic       busy_q = 1'b0;

    ultrasonic_ranger #(.CLKSPDMHZ(CLK), .TRIG_US(10), .TIMEOUT_US(2000), .HOLDOFF_US(100), .DIST_W(9)) dut (
        .clk(clk), .reset(reset), .start(start), .echo(echo), .trig(trig), .busy(busy),
        .dist_cm(dist_cm), .dist_valid(dist_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        busy_q <= busy;
        if (busy_q && !busy)
            t_bfall <= cyc;
        if (dist_valid) begin
            vcount    <= vcount + 1;
            last_dist <= int'(dist_cm);
            last_to   <= int'(timeout);
            t_prev    <= t_valid;
            t_valid   <= cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_trig_fall();
        int n = 0;
        while (!trig && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) chk("trig_rise_wait", n, 0);
        n = 0;
        while (trig && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("trig_fall_wait", n, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) chk("idle_wait", n, 0);
        @(negedge clk);
    endtask

    task automatic meas(input int d_us, input int w_us);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_trig_fall();
        start = 1'b0;
        repeat (d_us * CLK) @(negedge clk);
        echo = 1'b1;
        repeat (w_us * CLK) @(negedge clk);
        echo = 1'b0;
        wait_idle();
    endtask

    initial begin
        vec_t vecs[6];
        int   n, v0;
        vecs[0] = '{580, 580, 10, 0};
        vecs[1] = '{0, 57, 0, 0};
        vecs[2] = '{5, 1160, 20, 0};
        vecs[3] = '{3, 58, 1, 0};
        vecs[4] = '{2, 2000, 34, 0};
        vecs[5] = '{1, 2001, 511, 1};

        repeat (3) @(negedge clk);
        chk("rst_trig", int'(trig), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dist", int'(dist_cm), 0);
        chk("rst_valid", int'(dist_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

`ifdef ULTRASONIC_CONT_MEAS_EN
        v0 = vcount;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_trig_fall();
            start = (k == 2);
            repeat (20 * CLK) @(negedge clk);
            echo = 1'b1;
            repeat (290 * CLK) @(negedge clk);
            echo = 1'b0;
            repeat (5) @(negedge clk);
            chk("cont_count", vcount - v0, k + 1);
            chk("cont_dist", last_dist, 5);
            chk("cont_to", last_to, 0);
        end
        chk("cont_period", t_valid - t_prev, 100 + 200 + 3 + 2900 + 1000);
        wait_idle();
        start = 1'b0;
        repeat (2000) @(negedge clk);
        chk("cont_stop_busy", int'(busy), 0);
        chk("cont_stop_count", vcount - v0, 3);
`else
        // Echo never returns: exact trig width, then WAIT_ECHO timeout.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("trig_start", int'(trig), 1);
        chk("busy_start", int'(busy), 1);
        n = 0;
        while (trig && n < 200) begin @(negedge clk); n++; end
        chk("trig_width", n, 100);
        n = 0;
        while (!dist_valid && n < 30000) begin @(negedge clk); n++; end
        chk("wait_timeout_cycles", n, 20000);
        chk("wait_timeout_dist", int'(dist_cm), 511);
        chk("wait_timeout_flag", int'(timeout), 1);
        @(negedge clk);
        chk("valid_one_cycle", int'(dist_valid), 0);
        wait_idle();
        repeat (300) @(negedge clk);
        chk("held_start_idle", int'(busy), 0);
        chk("held_start_count", vcount, 1);
        chk("holdoff_len", t_bfall - t_valid, 1000);
        start = 1'b0;

        for (int i = 0; i < 6; i++) begin
            v0 = vcount;
            meas(vecs[i].d_us, vecs[i].w_us);
            chk($sformatf("vec%0d_count", i), vcount - v0, 1);
            chk($sformatf("vec%0d_dist", i), last_dist, vecs[i].exp_dist);
            chk($sformatf("vec%0d_to", i), last_to, vecs[i].exp_to);
        end

        // Second press during MEASURE is dropped.
        v0 = vcount;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_trig_fall();
        start = 1'b0;
        repeat (50) @(negedge clk);
        echo = 1'b1;
        repeat (3000) @(negedge clk);
        start = 1'b1;
        repeat (2000) @(negedge clk);
        start = 1'b0;
        repeat (800) @(negedge clk);
        echo = 1'b0;
        wait_idle();
        repeat (500) @(negedge clk);
        chk("busy_press_count", vcount - v0, 1);
        chk("busy_press_dist", last_dist, 10);
        chk("busy_press_holdoff", t_bfall - t_valid, 1000);
        chk("busy_press_idle", int'(busy), 0);

        // Reset while trig is high aborts the cycle.
        v0 = vcount;
        start = 1'b1;
        repeat (21) @(negedge clk);
        chk("pre_reset_trig", int'(trig), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_trig", int'(trig), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3000) @(negedge clk);
        chk("reset_no_valid", vcount - v0, 0);
        chk("reset_dist", int'(dist_cm), 0);
        chk("reset_idle", int'(busy), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
